fetch_prefetch_unit: RTL and testbench

// - Parametrised instruction-fetch front end: PC register, in-order instruction-memory request port,

---
 rtl/riscv_pipe_pkg.sv | 9 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/fetch_prefetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline constants for the instruction fetch front end
package riscv_pipe_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - registered-storage synchronous FIFO with clear, used as the prefetch queue
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign pop_ok = pop & ~empty;
  // A push into a full queue is only legal when the head leaves the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !clear && full && !pop_ok));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - decoupled instruction fetch: PC, in-order imem requests,
// outstanding/drop tracking for redirect squash, and a prefetch queue feeding decode.
module fetch_prefetch_unit #(
  parameter int               XLEN     = riscv_pipe_pkg::XLEN,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(riscv_pipe_pkg::RESET_PC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [31:0]                instrD,
  output logic [XLEN-1:0]            PCD,
  output logic [XLEN-1:0]            PCPlus4D,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  import riscv_pipe_pkg::ILEN;
  import riscv_pipe_pkg::NOP_INSTR;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = ILEN + 2 * XLEN;
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   rvalid_cnt;
  logic [CW-1:0]   issue_cnt;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_aligned;
  logic            redirect_lsb_unused;
  logic            issue;
  logic            push;
  logic            pop;
  logic            q_empty;
  logic [EW-1:0]   q_wdata;
  logic [EW-1:0]   q_head;

  assign redirect_aligned    = {redirect_pc[XLEN-1:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Credits cover queued entries plus every in-flight request, stale ones included,
  // so a returning response always has a free slot.
  assign credit_used = {1'b0, occupancy} + {1'b0, outstanding};
  assign imem_req    = rst & ~redirect_valid & (credit_used < DEPTH_LIM);
  assign imem_addr   = pc_f;
  assign issue       = imem_req & imem_gnt;

  assign rvalid_cnt = {{(CW-1){1'b0}}, imem_rvalid};
  assign issue_cnt  = {{(CW-1){1'b0}}, issue};

  assign push    = imem_rvalid & (drop_cnt == '0) & ~redirect_valid;
  assign q_wdata = {imem_rdata, resp_pc, resp_pc + XLEN'(4)};

  assign instr_valid = ~q_empty & ~redirect_valid;
  assign pop         = instr_valid & instr_ready;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (push),
    .wdata (q_wdata),
    .pop   (pop),
    .rdata (q_head),
    .empty (q_empty),
    .count (occupancy)
  );

  always_comb begin
    instrD   = NOP_INSTR;
    PCD      = '0;
    PCPlus4D = '0;
    if (!q_empty) begin
      instrD   = q_head[EW-1 -: ILEN];
      PCD      = q_head[2*XLEN-1 -: XLEN];
      PCPlus4D = q_head[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_f        <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old path.
      pc_f        <= redirect_aligned;
      resp_pc     <= redirect_aligned;
      outstanding <= outstanding - rvalid_cnt;
      drop_cnt    <= outstanding - rvalid_cnt;
    end else begin
      if (issue) pc_f <= pc_f + XLEN'(4);
      outstanding <= outstanding + issue_cnt - rvalid_cnt;
      if (imem_rvalid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        else                resp_pc  <= resp_pc + XLEN'(4);
      end
    end
  end

  no_orphan_response: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rvalid && outstanding == '0));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - self-checking bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;
  import riscv_pipe_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_gnt = 1'b0;
  logic imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic instr_valid;
  logic instr_ready = 1'b0;
  logic [31:0] instrD, PCD, PCPlus4D;
  logic [CW-1:0] occupancy;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .occupancy(occupancy)
  );

  // Reference: in-flight requests tagged with the fetch epoch they were issued in;
  // a redirect starts a new epoch and responses from older epochs are squashed.
  typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
  typedef struct {
    bit chk; bit rst; bit redir; logic [31:0] rpc; bit rdy; bit gnt;
    bit req; logic [31:0] addr; bit v; logic [31:0] pcd; int occ;
  } vec_t;

  req_t        pend[$];
  logic [31:0] q[$];
  logic [31:0] m_pc;
  int epoch, cyc, last_due, lat_min, lat_max;
  int n_vec, n_err;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, want);
    end
  endtask

  task automatic step_pre();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    @(negedge clk);
    chk("imem_req", imem_req, rst && !redirect_valid && (q.size() + pend.size() < DEPTH));
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, q.size() > 0 && !redirect_valid);
    chk("occupancy", occupancy, q.size());
    if (q.size() == 0) begin
      chk("instrD_empty", instrD, NOP_INSTR);
      chk("PCD_empty", PCD, 0);
      chk("PCPlus4D_empty", PCPlus4D, 0);
    end else if (!redirect_valid) begin
      chk("instrD", instrD, word(q[0]));
      chk("PCD", PCD, q[0]);
      chk("PCPlus4D", PCPlus4D, q[0] + 32'd4);
    end
  endtask

  task automatic step_post();
    req_t r;
    int   d;
    bit   issue;
    issue = rst && !redirect_valid && (q.size() + pend.size() < DEPTH) && imem_gnt;
    if (!rst) begin
      q.delete(); pend.delete();
      m_pc = RESET_PC; epoch = 0; last_due = 0;
    end else if (redirect_valid) begin
      if (imem_rvalid) void'(pend.pop_front());
      q.delete();
      epoch++;
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (q.size() > 0 && instr_ready) void'(q.pop_front());
      if (imem_rvalid) begin
        r = pend.pop_front();
        if (r.epoch == epoch) q.push_back(r.addr);
      end
      if (issue) begin
        d = cyc + int'($urandom_range(lat_min, lat_max));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        pend.push_back('{m_pc, d, epoch});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  vec_t tbl[$];
  bit   seen;
  int   seen_at;

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; epoch = 0; last_due = 0;
    lat_min = 1; lat_max = 1; m_pc = RESET_PC;
    @(posedge clk); #1; cyc = 1;

    // fill: one per cycle after 2-cycle fill
    tbl.push_back('{1,0,0,0,1,1, 0,32'h00,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h00,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h04,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h08,1,32'h00,1});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h0C,1,32'h04,1});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h10,1,32'h08,1});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h14,1,32'h0C,1});
    // stall 10 cycles, saturate, then drain in order
    tbl.push_back('{0,0,0,0,0,1, 0,32'h00,0,0,0});
    tbl.push_back('{1,1,0,0,0,1, 1,32'h00,0,0,0});
    tbl.push_back('{1,1,0,0,0,1, 1,32'h04,0,0,0});
    tbl.push_back('{1,1,0,0,0,1, 1,32'h08,1,32'h00,1});
    tbl.push_back('{1,1,0,0,0,1, 1,32'h0C,1,32'h00,2});
    tbl.push_back('{1,1,0,0,0,1, 0,32'h10,1,32'h00,3});
    for (int i = 0; i < 5; i++) tbl.push_back('{1,1,0,0,0,1, 0,32'h10,1,32'h00,4});
    tbl.push_back('{1,1,0,0,1,1, 0,32'h10,1,32'h00,4});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h10,1,32'h04,3});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h14,1,32'h08,2});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h18,1,32'h0C,2});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h1C,1,32'h10,2});
    // redirect to 0x83 together with a response and a pop
    tbl.push_back('{0,0,0,0,1,1, 0,32'h00,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h00,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h04,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h08,1,32'h00,1});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h0C,1,32'h04,1});
    tbl.push_back('{1,1,1,32'h83,1,1, 0,32'h10,0,0,1});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h80,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h84,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h88,1,32'h80,1});
    // grant held low 5 cycles
    tbl.push_back('{0,0,0,0,1,0, 0,32'h00,0,0,0});
    for (int i = 0; i < 5; i++) tbl.push_back('{1,1,0,0,1,0, 1,32'h00,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h00,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h04,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h08,1,32'h00,1});
    // PC wrap at the top of the address space
    tbl.push_back('{0,0,0,0,1,1, 0,32'h00,0,0,0});
    tbl.push_back('{1,1,1,32'hFFFF_FFFC,1,1, 0,32'h00,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'hFFFF_FFFC,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h00,0,0,0});
    tbl.push_back('{1,1,0,0,1,1, 1,32'h04,1,32'hFFFF_FFFC,1});

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc; instr_ready = tbl[i].rdy; imem_gnt = tbl[i].gnt;
      step_pre();
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
        chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].v);
        chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].occ);
        if (tbl[i].v) chk($sformatf("tbl%0d_pcd", i), PCD, tbl[i].pcd);
        if (tbl[i].v && tbl[i].pcd == 32'hFFFF_FFFC) chk("wrap_pcplus4", PCPlus4D, 32'h0);
      end
      step_post();
    end

    // redirect to 0x40 with two requests in flight on a 3-cycle memory
    lat_min = 3; lat_max = 3;
    redirect_valid = 0; instr_ready = 1; imem_gnt = 1;
    rst = 0; step_pre(); step_post();
    rst = 1; step_pre(); step_post(); step_pre(); step_post();
    redirect_valid = 1; redirect_pc = 32'h40; step_pre(); step_post();
    redirect_valid = 0;
    seen = 0; seen_at = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      step_pre();
      if (instr_valid) begin
        seen = 1; seen_at = i;
        chk("redir40_pcd", PCD, 32'h40);
        chk("redir40_pcplus4", PCPlus4D, 32'h44);
        chk("redir40_instr", instrD, word(32'h40));
      end
      step_post();
    end
    chk("redir40_seen", seen, 1);
    chk("redir40_latency", seen_at, 4);

    // reset mid-stream with a partly filled queue
    lat_min = 1; lat_max = 1; instr_ready = 0;
    for (int i = 0; i < 5; i++) begin step_pre(); step_post(); end
    rst = 0; step_pre(); step_post();
    step_pre();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instrD, NOP_INSTR);
    chk("rst_pcd", PCD, 0);
    chk("rst_pcplus4", PCPlus4D, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_addr", imem_addr, 0);
    step_post();

    // randomized traffic against the epoch model
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      rst            = ($urandom_range(0, 149) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom;
      instr_ready    = ($urandom_range(0, 3) != 0);
      imem_gnt       = ($urandom_range(0, 4) != 0);
      step_pre();
      step_post();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
